// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//   Shared types and helpers for the time-multiplexed FIR filter.
//   - fir_state_e : controller states (CLEAR, IDLE, MAC, OUT)
//   - fir_acc_w   : accumulator width that cannot overflow over TAPS products
//   - fir_chw     : channel index width (at least one bit)
//   - fir_reduce  : optional clamp of a shifted accumulator into WD_OUT bits
// ---------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      MAC,
      OUT
   } fir_state_e;

   function automatic int fir_acc_w(input int wd_in, input int wd_coef, input int taps);
      return wd_in + wd_coef + $clog2(taps);
   endfunction

   function automatic int fir_chw(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // With sat_en the value is clamped to the signed wd_out range. Without it the
   // value passes through unchanged, so the caller's narrowing cast wraps it.
   function automatic logic signed [63:0] fir_reduce(input logic signed [63:0] v,
                                                     input int wd_out,
                                                     input bit sat_en);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] r;
      hi = (64'sd1 <<< (wd_out - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (wd_out - 1));
      r  = v;
      if (sat_en) begin
         if (v > hi) r = hi;
         else if (v < lo) r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_tdm_filter_if.sv
// ---------------------------------------------------------------------------
// fir_tdm_filter_if
//   Bundles the streaming and coefficient-load signals of fir_tdm_filter.
//   Sample in : in_valid, in_ready, in_ch, data_in
//   Sample out: out_valid (one-cycle pulse), out_ch, data_out
//   Coef load : coef_we, coef_addr, coef_data
//   Status    : busy
//   Modports  : master (source/sink side), slave (filter side).
// ---------------------------------------------------------------------------
interface fir_tdm_filter_if
   import fir_pkg::*;
#(
   parameter int WD_IN   = 24,
   parameter int WD_OUT  = 24,
   parameter int WD_COEF = 16,
   parameter int TAPS    = 16,
   parameter int N_CH    = 2
) ();

   localparam int CHW = fir_chw(N_CH);
   localparam int TW  = $clog2(TAPS);

   logic               in_valid;
   logic               in_ready;
   logic [CHW-1:0]     in_ch;
   logic [WD_IN-1:0]   data_in;
   logic               out_valid;
   logic [CHW-1:0]     out_ch;
   logic [WD_OUT-1:0]  data_out;
   logic               coef_we;
   logic [TW-1:0]      coef_addr;
   logic [WD_COEF-1:0] coef_data;
   logic               busy;

   modport master (
      output in_valid, in_ch, data_in, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_ch, data_out, busy
   );

   modport slave (
      input  in_valid, in_ch, data_in, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_ch, data_out, busy
   );

endinterface

// File: rtl/fir_tdm_mac.sv
// ---------------------------------------------------------------------------
// fir_tdm_mac
//   Registered signed multiply-accumulate shared by all channels.
//   clk    in  : clock
//   coef   in  : signed coefficient
//   sample in  : signed delay-line sample
//   clr    in  : zero the accumulator (wins over en)
//   en     in  : add coef*sample to the accumulator
//   acc    out : signed accumulator
// ---------------------------------------------------------------------------
module fir_tdm_mac #(
   parameter int WD_IN   = 24,
   parameter int WD_COEF = 16,
   parameter int ACC_W   = 44
) (
   input  logic                      clk,
   input  logic signed [WD_COEF-1:0] coef,
   input  logic signed [WD_IN-1:0]   sample,
   input  logic                      clr,
   input  logic                      en,
   output logic signed [ACC_W-1:0]   acc
);

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] prod;

   always_comb begin
      prod  = ACC_W'(coef) * ACC_W'(sample);
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + prod;
   end

   // Datapath register: always cleared before use, so it carries no reset.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_tdm_filter.sv
// ---------------------------------------------------------------------------
// fir_tdm_filter
//   Multi-channel time-multiplexed FIR. One MAC serves N_CH channels, each with
//   its own TAPS-deep circular delay line and write pointer.
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus      : fir_tdm_filter_if.slave (sample in/out, coef load, busy)
//   Build option: define FIR_SATURATE_EN to clamp the output into the signed
//   WD_OUT range; otherwise the low WD_OUT bits are kept (two's-complement wrap).
// ---------------------------------------------------------------------------
module fir_tdm_filter
   import fir_pkg::*;
#(
   parameter int WD_IN   = 24,
   parameter int WD_OUT  = 24,
   parameter int WD_COEF = 16,
   parameter int TAPS    = 16,
   parameter int N_CH    = 2,
   parameter int SHIFT   = 15
) (
   input logic              clk,
   input logic              rst_n,
   fir_tdm_filter_if.slave  bus
);

   localparam int ACC_W = fir_acc_w(WD_IN, WD_COEF, TAPS);
   localparam int CHW   = fir_chw(N_CH);
   localparam int TW    = $clog2(TAPS);
`ifdef FIR_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   fir_state_e                state_q, state_d;
   logic [TW-1:0]             k_q, k_d;
   logic [CHW-1:0]            clr_ch_q, clr_ch_d;
   logic [CHW-1:0]            ch_q, ch_d;
   logic [TW-1:0]             wp_q [N_CH];
   logic [TW-1:0]             wp_d [N_CH];
   logic signed [WD_COEF-1:0] coef_q [TAPS];
   logic signed [WD_COEF-1:0] coef_d [TAPS];
   logic                      out_valid_q, out_valid_d;
   logic [CHW-1:0]            out_ch_q, out_ch_d;
   logic [WD_OUT-1:0]         data_out_q, data_out_d;

   logic signed [WD_IN-1:0]   dline_mem [N_CH][TAPS];
   logic                      mem_we;
   logic [CHW-1:0]            mem_wch;
   logic [TW-1:0]             mem_wtap;
   logic signed [WD_IN-1:0]   mem_wdata;

   logic [TW-1:0]             rd_tap;
   logic signed [WD_IN-1:0]   rd_sample;
   logic                      mac_clr, mac_en, in_ready_c, ch_ok;
   logic signed [ACC_W-1:0]   acc;

   // Tap k reads x[n-k]: step back k places from the newest word, modulo TAPS.
   always_comb begin
      int s;
      s = int'(wp_q[ch_q]) + TAPS - int'(k_q);
      if (s >= TAPS) s = s - TAPS;
      rd_tap = TW'(s);
   end

   assign rd_sample = dline_mem[ch_q][rd_tap];
   assign ch_ok     = (int'(bus.in_ch) < N_CH);

   fir_tdm_mac #(.WD_IN(WD_IN), .WD_COEF(WD_COEF), .ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .coef   (coef_q[k_q]),
      .sample (rd_sample),
      .clr    (mac_clr),
      .en     (mac_en),
      .acc    (acc)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      clr_ch_d    = clr_ch_q;
      ch_d        = ch_q;
      wp_d        = wp_q;
      coef_d      = coef_q;
      out_valid_d = 1'b0;
      out_ch_d    = out_ch_q;
      data_out_d  = data_out_q;
      mem_we      = 1'b0;
      mem_wch     = clr_ch_q;
      mem_wtap    = k_q;
      mem_wdata   = '0;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;
      in_ready_c  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            // k_q doubles as the tap index of the word being zeroed.
            mem_we = 1'b1;
            if (k_q == TW'(TAPS - 1)) begin
               k_d = '0;
               if (clr_ch_q == CHW'(N_CH - 1)) begin
                  clr_ch_d = '0;
                  state_d  = IDLE;
               end else begin
                  clr_ch_d = clr_ch_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         IDLE: begin
            in_ready_c = !bus.coef_we;
            if (bus.coef_we) begin
               coef_d[bus.coef_addr] = bus.coef_data;
            end else if (bus.in_valid && ch_ok) begin
               // Out-of-range channels are accepted but leave no trace.
               mem_we    = 1'b1;
               mem_wch   = bus.in_ch;
               mem_wtap  = wp_q[bus.in_ch];
               mem_wdata = bus.data_in;
               ch_d      = bus.in_ch;
               mac_clr   = 1'b1;
               k_d       = '0;
               state_d   = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (k_q == TW'(TAPS - 1)) begin
               k_d     = '0;
               state_d = OUT;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         OUT: begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_q;
            data_out_d  = WD_OUT'(fir_reduce(64'(acc) >>> SHIFT, WD_OUT, SAT_EN));
            wp_d[ch_q]  = (wp_q[ch_q] == TW'(TAPS - 1)) ? '0 : wp_q[ch_q] + 1'b1;
            state_d     = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         k_q         <= '0;
         clr_ch_q    <= '0;
         ch_q        <= '0;
         wp_q        <= '{default: '0};
         coef_q      <= '{default: '0};
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         clr_ch_q    <= clr_ch_d;
         ch_q        <= ch_d;
         wp_q        <= wp_d;
         coef_q      <= coef_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         data_out_q  <= data_out_d;
      end
   end

   // Delay-line RAM: no reset, the CLEAR sweep initialises it.
   always_ff @(posedge clk) begin
      if (mem_we) dline_mem[mem_wch][mem_wtap] <= mem_wdata;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.data_out  = data_out_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tdm_filter.sv
module tb_fir_tdm_filter;
   import fir_pkg::*;

   localparam int WD_IN = 24, WD_OUT = 24, WD_COEF = 16, TAPS = 16, N_CH = 2, SHIFT = 0;
   localparam int CHW = fir_chw(N_CH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fir_tdm_filter_if #(.WD_IN(WD_IN), .WD_OUT(WD_OUT), .WD_COEF(WD_COEF),
                       .TAPS(TAPS), .N_CH(N_CH)) bus ();

   fir_tdm_filter #(.WD_IN(WD_IN), .WD_OUT(WD_OUT), .WD_COEF(WD_COEF),
                    .TAPS(TAPS), .N_CH(N_CH), .SHIFT(SHIFT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      int                ch;
      logic [WD_OUT-1:0] d;
      int                acc_cyc;
   } exp_t;

   exp_t              exp_q[$];
   logic [WD_OUT-1:0] log_d[$];
   int                log_ch[$];
   longint            m_coef [TAPS];
   longint            m_hist [N_CH][TAPS];   // index 0 = newest sample
   int                cyc = 0;
   int                checks = 0;
   int                errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Model: y = sum_k coef[k]*x[n-k], arithmetic shift, then clamp or wrap.
   function automatic logic [WD_OUT-1:0] m_reduce(input longint a);
      longint     s, hi, lo;
      logic [63:0] u;
      s  = a >>> SHIFT;
      hi = (longint'(1) <<< (WD_OUT - 1)) - 1;
      lo = -(longint'(1) <<< (WD_OUT - 1));
`ifdef FIR_SATURATE_EN
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`else
      if (hi < lo) s = 0;
`endif
      u = s;
      return u[WD_OUT-1:0];
   endfunction

   function automatic logic [WD_OUT-1:0] m_filter(input int ch);
      longint acc = 0;
      for (int k = 0; k < TAPS; k++) acc += m_coef[k] * m_hist[ch][k];
      return m_reduce(acc);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
   endtask

   task automatic accept(input int ch, input logic [WD_IN-1:0] d, input int ac);
      exp_t e;
      for (int k = TAPS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = longint'($signed(d));
      e.ch = ch;
      e.d = m_filter(ch);
      e.acc_cyc = ac;
      exp_q.push_back(e);
   endtask

   // Compare process: every out_valid pulse is matched against the model.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         log_d.push_back(bus.data_out);
         log_ch.push_back(int'(bus.out_ch));
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got pulse ch=%0d data=0x%0h, expected none",
                     bus.out_ch, bus.data_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", 64'(bus.data_out), 64'(e.d));
            check("out_ch", 64'(bus.out_ch), 64'(e.ch));
            check("latency", 64'(cyc - e.acc_cyc), 64'(TAPS + 1));
         end
      end
   end

   task automatic send(input int ch, input logic [WD_IN-1:0] d);
      int a;
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_ch = CHW'(ch);
      bus.data_in = d;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
         bus.in_valid = 1'b0;
         return;
      end
      a = cyc;
      @(posedge clk);
      accept(ch, d, a + 1);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic write_coef(input int addr, input logic [WD_COEF-1:0] val);
      @(negedge clk);
      bus.coef_we = 1'b1;
      bus.coef_addr = 4'(addr);
      bus.coef_data = val;
      @(posedge clk);
      m_coef[addr] = longint'($signed(val));
      #1 bus.coef_we = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic reset_and_clear(input string tag);
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      bus.in_valid = 1'b0;
      bus.coef_we = 1'b0;
      #2;
      check({tag, "_rst_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_rst_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_rst_out_ch"}, 64'(bus.out_ch), 64'd0);
      check({tag, "_rst_data_out"}, 64'(bus.data_out), 64'd0);
      check({tag, "_rst_busy"}, 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
      end
      check({tag, "_clear_cycles"}, 64'(n), 64'(N_CH * TAPS));
      check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_idle_data_out"}, 64'(bus.data_out), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WD_OUT-1:0] ch1_ramp [16];
      int n0, n1, a;
      ch1_ramp = '{24'h10, 24'h30, 24'h60, 24'hA0, 24'hF0, 24'h150, 24'h1C0, 24'h240,
                   24'h2D0, 24'h370, 24'h420, 24'h4E0, 24'h5B0, 24'h690, 24'h780, 24'h880};
      bus.in_valid = 1'b0;
      bus.in_ch = '0;
      bus.data_in = '0;
      bus.coef_we = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;

      // Power-on reset and delay-line clear
      reset_and_clear("por");

      // Impulse response with coef[k] = k+1
      for (int k = 0; k < TAPS; k++) write_coef(k, WD_COEF'(k + 1));
      log_d.delete(); log_ch.delete();
      send(0, 24'd1);
      for (int i = 0; i < 16; i++) send(0, 24'd0);
      drain();
      check("impulse_count", 64'(log_d.size()), 64'd17);
      for (int i = 0; i < 16; i++) check("impulse_tap", 64'(log_d[i]), 64'(i + 1));
      check("impulse_tail", 64'(log_d[16]), 64'd0);

      // Channel isolation: interleaved ch0 impulse and ch1 constant
      log_d.delete(); log_ch.delete();
      for (int i = 0; i < 16; i++) begin
         send(0, (i == 0) ? 24'd1 : 24'd0);
         send(1, 24'h10);
      end
      drain();
      n0 = 0; n1 = 0;
      for (int i = 0; i < log_d.size(); i++) begin
         if (log_ch[i] == 0) begin
            check("iso_ch0", 64'(log_d[i]), 64'(n0 + 1));
            n0++;
         end else begin
            check("iso_ch1", 64'(log_d[i]), 64'(ch1_ramp[n1 % 16]));
            n1++;
         end
      end
      check("iso_ch0_count", 64'(n0), 64'd16);
      check("iso_ch1_count", 64'(n1), 64'd16);

      // Contention: coef write beats a simultaneous sample
      log_d.delete(); log_ch.delete();
      @(negedge clk);
      bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 16'd100;
      bus.in_valid = 1'b1; bus.in_ch = 1'b1; bus.data_in = 24'd3;
      #1 check("contend_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      m_coef[0] = 100;
      @(negedge clk);
      bus.coef_we = 1'b0;
      #1 check("contend_retry_ready", 64'(bus.in_ready), 64'd1);
      a = cyc;
      @(posedge clk);
      accept(1, 24'd3, a + 1);
      #1 bus.in_valid = 1'b0;
      // Write attempted during MAC is dropped; the model keeps the old coef.
      repeat (3) @(negedge clk);
      bus.coef_we = 1'b1; bus.coef_addr = 4'd1; bus.coef_data = 16'h1234;
      #1 check("contend_busy", 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1 bus.coef_we = 1'b0;
      drain();
      send(0, 24'd1);
      send(0, 24'd0);
      drain();
      check("contend_count", 64'(log_d.size()), 64'd3);
      check("contend_ch1", 64'(log_d[0]), 64'h99C);
      check("contend_coef0", 64'(log_d[1]), 64'd100);
      check("contend_coef1_kept", 64'(log_d[2]), 64'd2);

      // Saturation / wrap with full-scale coefs and samples
      for (int k = 0; k < TAPS; k++) write_coef(k, 16'h7FFF);
      log_d.delete(); log_ch.delete();
      for (int i = 0; i < 16; i++) send(0, 24'h7FFFFF);
      drain();
`ifdef FIR_SATURATE_EN
      check("sat_last", 64'(log_d[log_d.size() - 1]), 64'h7FFFFF);
`else
      check("wrap_last", 64'(log_d[log_d.size() - 1]), 64'hF80010);
`endif

      // Reset in the middle of a MAC pass
      send(0, 24'd5);
      repeat (5) @(negedge clk);
      log_d.delete(); log_ch.delete();
      reset_and_clear("midop");
      repeat (30) @(negedge clk);
      check("midop_no_pulse", 64'(log_d.size()), 64'd0);
      send(0, 24'd1);
      for (int i = 0; i < 16; i++) send(0, 24'd0);
      drain();
      check("midop_count", 64'(log_d.size()), 64'd17);
      for (int i = 0; i < log_d.size(); i++) check("midop_zero_coef", 64'(log_d[i]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
